// File: rtl/my_spi_pkg.sv
// rtl/my_spi_pkg.sv - MySPI register map and frame layout shared by master and slave
package my_spi_pkg;

   localparam logic [6:0] ADDR_CONFIG  = 7'h00;
   localparam logic [6:0] ADDR_STATUS  = 7'h01;
   localparam logic [6:0] ADDR_DIR_R   = 7'h10;
   localparam logic [6:0] ADDR_SPEED_R1 = 7'h11;
   localparam logic [6:0] ADDR_SPEED_R2 = 7'h12;
   localparam logic [6:0] ADDR_DIR_L   = 7'h20;
   localparam logic [6:0] ADDR_SPEED_L1 = 7'h21;
   localparam logic [6:0] ADDR_SPEED_L2 = 7'h22;

   localparam int WRITE_FLAG_BIT = 7;
   localparam int FRAME_BITS     = 16;

   // Reads shift 0x00 in the data phase so the slave never sees stale write data.
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic       wr,
                                                         input logic [6:0] addr,
                                                         input logic [7:0] wdata);
      logic [7:0] hdr;
      hdr = {1'b0, addr};
      hdr[WRITE_FLAG_BIT] = wr;
      return {hdr, (wr ? wdata : 8'h00)};
   endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - command/response handshake between a requester and the SPI master
interface spi_master_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [6:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/spi_phase_timer.sv
// rtl/spi_phase_timer.sv - loadable down-counter timing each SPI frame phase
module spi_phase_timer #(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rstn_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         done_o
);
   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] cnt_q, cnt_d;

   // Loading N gives done on the N-th cycle after the load edge.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i - ONE;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - ONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);
endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI mode-0 master issuing single 16-bit MySPI register frames
module spi_master_ctrl
   import my_spi_pkg::*;
#(
   parameter int CLK_DIV  = 8,
   parameter int CS_SETUP = 4,
   parameter int CS_HOLD  = 4,
   parameter int CS_GAP   = 4
) (
   input  logic             theClock,
   input  logic             theReset,
   spi_master_ctrl_if.slave bus,
   output logic             busy,
   output logic             spi_clk,
   output logic             spi_cs_n,
   output logic             spi_mosi,
   input  logic             spi_miso
);
   localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int MAX_B = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
   localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int TW    = $clog2(MAX_P) + 1;

   localparam logic [TW-1:0] T_DIV   = TW'(CLK_DIV);
   localparam logic [TW-1:0] T_SETUP = TW'(CS_SETUP);
   localparam logic [TW-1:0] T_HOLD  = TW'(CS_HOLD);
   localparam logic [TW-1:0] T_GAP   = TW'(CS_GAP);
   localparam logic [4:0]    BIT_END = 5'(FRAME_BITS);

   typedef logic [2:0] spi_m_state_t;
   localparam spi_m_state_t S_IDLE  = 3'd0;
   localparam spi_m_state_t S_SETUP = 3'd1;
   localparam spi_m_state_t S_LOW   = 3'd2;
   localparam spi_m_state_t S_HIGH  = 3'd3;
   localparam spi_m_state_t S_HOLD  = 3'd4;
   localparam spi_m_state_t S_GAP   = 3'd5;

   spi_m_state_t state_q, state_d;
   logic [15:0]  shift_q, shift_d;
   logic [7:0]   rx_q, rx_d;
   logic [7:0]   rdata_q, rdata_d;
   logic [4:0]   bit_q, bit_d, bit_inc;
   logic         rsp_valid_q, rsp_valid_d;
   logic         cs_n_q, cs_n_d;
   logic         sclk_q, sclk_d;
   logic         mosi_q, mosi_d;
   logic         active_d;
   logic         tmr_load, tmr_done;
   logic [TW-1:0] tmr_val;

   spi_phase_timer #(.W(TW)) u_timer (
      .clk_i      (theClock),
      .rstn_i     (theReset),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .done_o     (tmr_done)
   );

   assign bit_inc = (bit_q >= BIT_END) ? bit_q : bit_q + 5'd1;

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      rx_d        = rx_q;
      bit_d       = bit_q;
      rdata_d     = rdata_q;
      rsp_valid_d = 1'b0;
      tmr_load    = 1'b0;
      tmr_val     = T_DIV;
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               state_d  = S_SETUP;
               shift_d  = build_frame(bus.cmd_write, bus.cmd_addr, bus.cmd_wdata);
               bit_d    = '0;
               tmr_load = 1'b1;
               tmr_val  = T_SETUP;
            end
         end
         S_SETUP: begin
            if (tmr_done) begin
               state_d  = S_LOW;
               tmr_load = 1'b1;
            end
         end
         S_LOW: begin
            // Entering HIGH is the SCLK rise: MISO is sampled on this edge.
            if (tmr_done) begin
               state_d  = S_HIGH;
               rx_d     = {rx_q[6:0], spi_miso};
               tmr_load = 1'b1;
            end
         end
         S_HIGH: begin
            if (tmr_done) begin
               bit_d    = bit_inc;
               tmr_load = 1'b1;
               if (bit_inc < BIT_END) begin
                  state_d = S_LOW;
                  shift_d = {shift_q[14:0], 1'b0};
               end else begin
                  state_d = S_HOLD;
                  tmr_val = T_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (tmr_done) begin
               state_d     = S_GAP;
               rsp_valid_d = 1'b1;
               rdata_d     = rx_q;
               tmr_load    = 1'b1;
               tmr_val     = T_GAP;
            end
         end
         S_GAP: begin
            if (tmr_done) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Pin values are registered from the next state so SCLK/CS/MOSI never glitch.
   assign active_d = (state_d == S_SETUP) || (state_d == S_LOW) ||
                     (state_d == S_HIGH)  || (state_d == S_HOLD);
   assign cs_n_d   = !active_d;
   assign sclk_d   = (state_d == S_HIGH);
   assign mosi_d   = active_d ? shift_d[15] : 1'b0;

   always_ff @(posedge theClock) begin
      if (!theReset) begin
         state_q     <= S_IDLE;
         shift_q     <= '0;
         rx_q        <= '0;
         bit_q       <= '0;
         rdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         cs_n_q      <= 1'b1;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         rx_q        <= rx_d;
         bit_q       <= bit_d;
         rdata_q     <= rdata_d;
         rsp_valid_q <= rsp_valid_d;
         cs_n_q      <= cs_n_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
      end
   end

   assign bus.cmd_ready = (state_q == S_IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign busy          = (state_q != S_IDLE);
   assign spi_clk       = sclk_q;
   assign spi_cs_n      = cs_n_q;
   assign spi_mosi      = mosi_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - scoreboard bench for spi_master_ctrl against a MySPI slave model
module tb_spi_master_ctrl;
   logic theClock = 1'b0;
   logic theReset = 1'b0;
   always #5 theClock = ~theClock;

   spi_master_ctrl_if b1 ();
   spi_master_ctrl_if b2 ();

   logic busy1, clk1, cs1, mosi1;
   logic busy2, clk2, cs2, mosi2;
   logic miso = 1'b0;

   spi_master_ctrl dut1 (
      .theClock (theClock), .theReset (theReset), .bus (b1),
      .busy (busy1), .spi_clk (clk1), .spi_cs_n (cs1), .spi_mosi (mosi1), .spi_miso (miso)
   );

   spi_master_ctrl #(.CLK_DIV(4), .CS_SETUP(4), .CS_HOLD(4), .CS_GAP(4)) dut2 (
      .theClock (theClock), .theReset (theReset), .bus (b2),
      .busy (busy2), .spi_clk (clk2), .spi_cs_n (cs2), .spi_mosi (mosi2), .spi_miso (miso)
   );

   // Slave model: one MySPI register file shared by both masters through a mux.
   logic sel2 = 1'b0;
   wire  s_clk  = sel2 ? clk2  : clk1;
   wire  s_cs   = sel2 ? cs2   : cs1;
   wire  s_mosi = sel2 ? mosi2 : mosi1;
   logic [7:0]  mem [0:127];
   logic [15:0] s_frame = '0;
   logic [15:0] last_frame = '0;
   logic [7:0]  s_out = '0;
   int          nrise = 0;

   always @(negedge s_cs) begin
      nrise = 0; s_frame = '0; miso = 1'b0;
   end
   always @(posedge s_clk) if (s_cs === 1'b0) begin
      s_frame = {s_frame[14:0], s_mosi}; nrise++;
   end
   always @(negedge s_clk) if (s_cs === 1'b0) begin
      if (nrise == 8) begin
         s_out = mem[s_frame[6:0]]; miso = s_out[7];
      end else if (nrise > 8 && nrise < 16) begin
         s_out = {s_out[6:0], 1'b0}; miso = s_out[7];
      end
   end
   always @(posedge s_cs) if (nrise == 16) begin
      last_frame = s_frame;
      if (s_frame[15]) mem[s_frame[14:8]] = s_frame[7:0];
   end

   typedef struct { logic [15:0] frame; logic [7:0] rdata; bit on2; } exp_t;
   exp_t expq[$];
   int n_cmp = 0, n_bad = 0, rsp_n = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   int cyc = 0, acc1_t = 0, acc2_t = 0, prev_acc1_t = 0, acc1_n = 0, acc2_n = 0;
   always @(posedge theClock) begin
      if (theReset && b1.cmd_valid && b1.cmd_ready) begin
         prev_acc1_t = acc1_t; acc1_t = cyc; acc1_n++;
      end
      if (theReset && b2.cmd_valid && b2.cmd_ready) begin
         acc2_t = cyc; acc2_n++;
      end
      cyc++;
   end

   task automatic handle(input bit on2, input logic [7:0] rd, input int lat);
      exp_t e;
      if (expq.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL unexpected_rsp: got rsp_valid with rdata 0x%0h, required none", rd);
      end else begin
         e = expq.pop_front();
         chk("rsp_dut", 32'(on2), 32'(e.on2));
         chk("rsp_rdata", rd, e.rdata);
         chk("mosi_frame", last_frame, e.frame);
         chk("rsp_latency", lat, on2 ? 137 : 265);
         rsp_n++;
      end
   endtask

   logic rdy1_p = 1'b1, rdy2_p = 1'b1, cs1_p = 1'b1, rv1_p = 1'b0, rv2_p = 1'b0;
   bit   abort1 = 1'b0;
   int   cs1_rise = -1000;
   always @(negedge theClock) begin
      if (b1.rsp_valid === 1'b1) handle(1'b0, b1.rsp_rdata, cyc - acc1_t);
      if (b2.rsp_valid === 1'b1) handle(1'b1, b2.rsp_rdata, cyc - acc2_t);
      if (rv1_p) chk("rsp1_single_pulse", b1.rsp_valid, 0);
      if (rv2_p) chk("rsp2_single_pulse", b2.rsp_valid, 0);
      if (cs1_p && !cs1) begin
         chk("cs_fall_time", cyc - acc1_t, 1);
         chk("cs_gap_ge4", 32'(cyc - cs1_rise >= 4), 1);
      end
      if (!cs1_p && cs1) begin
         cs1_rise = cyc;
         if (!abort1) chk("cs_rise_time", cyc - acc1_t, 265);
      end
      if (theReset && b1.cmd_ready && !rdy1_p) begin
         if (abort1) abort1 = 1'b0;
         else        chk("ready1_time", cyc - acc1_t, 269);
      end
      if (theReset && b2.cmd_ready && !rdy2_p) chk("ready2_time", cyc - acc2_t, 141);
      rdy1_p = b1.cmd_ready; rdy2_p = b2.cmd_ready; cs1_p = cs1;
      rv1_p = b1.rsp_valid; rv2_p = b2.rsp_valid;
   end

   task automatic tick();
      @(posedge theClock); #1;
   endtask

   task automatic wait_acc1(input int n0);
      for (int i = 0; i < 400 && acc1_n == n0; i++) tick();
      chk("accept1_seen", 32'(acc1_n != n0), 1);
   endtask

   task automatic issue1(input bit wr, input logic [6:0] a, input logic [7:0] wd);
      int n0;
      n0 = acc1_n;
      b1.cmd_write = wr; b1.cmd_addr = a; b1.cmd_wdata = wd; b1.cmd_valid = 1'b1;
      wait_acc1(n0);
      b1.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int target);
      for (int i = 0; i < 600 && rsp_n < target; i++) tick();
      chk("rsp_arrived", 32'(rsp_n >= target), 1);
   endtask

   task automatic wait_idle1();
      for (int i = 0; i < 50 && b1.cmd_ready !== 1'b1; i++) tick();
   endtask

   initial begin
      int n0;
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      mem[7'h01] = 8'h5A; mem[7'h11] = 8'h12; mem[7'h12] = 8'h34;
      mem[7'h21] = 8'hBE; mem[7'h22] = 8'hEF;
      b1.cmd_valid = 0; b1.cmd_write = 0; b1.cmd_addr = '0; b1.cmd_wdata = '0;
      b2.cmd_valid = 0; b2.cmd_write = 0; b2.cmd_addr = '0; b2.cmd_wdata = '0;
      repeat (3) tick();
      chk("reset_cs_n", cs1, 1);
      chk("reset_clk", clk1, 0);
      chk("reset_mosi", mosi1, 0);
      chk("reset_rsp_valid", b1.rsp_valid, 0);
      chk("reset_rdata", b1.rsp_rdata, 8'h00);
      chk("reset_busy", busy1, 0);
      chk("reset_ready", b1.cmd_ready, 1);
      theReset = 1'b1;
      tick();

      expq.push_back('{16'h80A5, 8'h00, 1'b0});
      issue1(1'b1, 7'h00, 8'hA5);
      wait_rsp(1);
      chk("config_after_write", mem[7'h00], 8'hA5);
      wait_idle1();

      expq.push_back('{16'h0000, 8'hA5, 1'b0});
      issue1(1'b0, 7'h00, 8'h5C);
      wait_rsp(2);
      wait_idle1();

      expq.push_back('{16'h1100, 8'h12, 1'b0});
      issue1(1'b0, 7'h11, 8'h00);
      wait_rsp(3);
      chk("config_after_read", mem[7'h00], 8'hA5);
      wait_idle1();

      expq.push_back('{16'h1200, 8'h34, 1'b0});
      expq.push_back('{16'h2100, 8'hBE, 1'b0});
      n0 = acc1_n;
      b1.cmd_write = 1'b0; b1.cmd_addr = 7'h12; b1.cmd_wdata = 8'h00; b1.cmd_valid = 1'b1;
      wait_acc1(n0);
      b1.cmd_addr = 7'h21;
      wait_acc1(n0 + 1);
      b1.cmd_valid = 1'b0;
      chk("b2b_accept_spacing", acc1_t - prev_acc1_t, 269);
      wait_rsp(5);
      wait_idle1();

      issue1(1'b1, 7'h00, 8'h5A);
      for (int i = 0; i < 400 && nrise < 10; i++) tick();
      abort1 = 1'b1;
      theReset = 1'b0;
      tick();
      chk("abort_cs_n", cs1, 1);
      chk("abort_clk", clk1, 0);
      chk("abort_rsp_valid", b1.rsp_valid, 0);
      chk("abort_rdata", b1.rsp_rdata, 8'h00);
      theReset = 1'b1;
      tick();
      chk("abort_ready", b1.cmd_ready, 1);
      repeat (20) tick();
      chk("abort_config_kept", mem[7'h00], 8'hA5);
      chk("abort_no_rsp", rsp_n, 5);

      expq.push_back('{16'h803C, 8'hA5, 1'b0});
      issue1(1'b1, 7'h00, 8'h3C);
      n0 = acc1_n;
      repeat (40) tick();
      b1.cmd_write = 1'b0; b1.cmd_addr = 7'h7F; b1.cmd_wdata = 8'hFF; b1.cmd_valid = 1'b1;
      chk("latch_busy", busy1, 1);
      chk("latch_ready_low", b1.cmd_ready, 0);
      tick();
      b1.cmd_valid = 1'b0;
      repeat (150) tick();
      chk("latch_busy_late", busy1, 1);
      wait_rsp(6);
      chk("latch_no_second_accept", acc1_n, n0);
      chk("latch_config_written", mem[7'h00], 8'h3C);
      wait_idle1();

      sel2 = 1'b1;
      expq.push_back('{16'h0100, 8'h5A, 1'b1});
      n0 = acc2_n;
      b2.cmd_write = 1'b0; b2.cmd_addr = 7'h01; b2.cmd_wdata = 8'h00; b2.cmd_valid = 1'b1;
      for (int i = 0; i < 50 && acc2_n == n0; i++) tick();
      b2.cmd_valid = 1'b0;
      chk("accept2_seen", 32'(acc2_n != n0), 1);
      wait_rsp(7);
      repeat (10) tick();
      chk("dut2_idle", b2.cmd_ready, 1);
      chk("queue_drained", expq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end
endmodule
